// File: rtl/bnn_window_gen_if.sv
// Pixel-in / window-out handshake bundle for bnn_window_gen.
// The master drives pixels and win_ready; the slave (the window generator) drives in_ready and the window payload.
interface bnn_window_gen_if #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned C     = 3
);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned DW = 9 * C;

    logic          in_valid;
    logic          in_ready;
    logic [C-1:0]  in_data;
    logic          win_valid;
    logic          win_ready;
    logic [DW-1:0] win_data;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          win_last;

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_x, win_y, win_last
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_x, win_y, win_last
    );
endinterface

// File: rtl/bnn_window_gen.sv
// Streaming 3x3 sliding-window generator for C-channel binary feature maps.
// Two line buffers plus a two-column shift register feed a single registered window output stage.
module bnn_window_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned C     = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    bnn_window_gen_if.slave     bus
);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned DW = 9 * C;

    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [C-1:0]  r_lb0 [IMG_W];
    logic [C-1:0]  r_lb1 [IMG_W];
    logic [C-1:0]  r_sh  [3][2];

    logic          r_win_valid;
    logic [DW-1:0] r_win_data;
    logic [XW-1:0] r_win_x;
    logic [YW-1:0] r_win_y;
    logic          r_win_last;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_emit;
    logic          w_col_last;
    logic          w_row_last;
    logic [C-1:0]  w_new [3];
    logic [C-1:0]  w_tap [3][3];
    logic [DW-1:0] w_win_pack;

    assign w_in_ready = !r_win_valid || bus.win_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !clear;
    assign w_col_last = (r_col == XW'(IMG_W - 1));
    assign w_row_last = (r_row == YW'(IMG_H - 1));
    assign w_emit     = w_accept && (r_row >= YW'(2)) && (r_col >= XW'(2));

    assign bus.in_ready  = w_in_ready;
    assign bus.win_valid = r_win_valid;
    assign bus.win_data  = r_win_data;
    assign bus.win_x     = r_win_x;
    assign bus.win_y     = r_win_y;
    assign bus.win_last  = r_win_last;

    // Post-shift window: two stored columns on the left, the incoming column on the right.
    always_comb begin
        w_win_pack = '0;
        w_new[0]   = r_lb0[r_col];
        w_new[1]   = r_lb1[r_col];
        w_new[2]   = bus.in_data;
        for (int r = 0; r < 3; r++) begin
            w_tap[r][0] = r_sh[r][0];
            w_tap[r][1] = r_sh[r][1];
            w_tap[r][2] = w_new[r];
        end
        for (int ch = 0; ch < int'(C); ch++) begin
            for (int r = 0; r < 3; r++) begin
                for (int s = 0; s < 3; s++) begin
                    w_win_pack[ch*9 + 3*r + s] = w_tap[r][s][ch];
                end
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + YW'(1);
            end else begin
                r_col <= r_col + XW'(1);
            end
        end
    end

    // Line buffers and shift columns are overwritten before any emit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= bus.in_data;
            for (int r = 0; r < 3; r++) begin
                r_sh[r][0] <= r_sh[r][1];
                r_sh[r][1] <= w_new[r];
            end
        end
    end

    // Output stage: a new window overwrites a consumed one in the same cycle without a bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_win_last  <= 1'b0;
        end else if (clear) begin
            r_win_valid <= 1'b0;
        end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_win_pack;
            r_win_x     <= r_col - XW'(2);
            r_win_y     <= r_row - YW'(2);
            r_win_last  <= w_col_last && w_row_last;
        end else if (bus.win_ready) begin
            r_win_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bnn_window_gen.sv
// Directed bench for bnn_window_gen on a 4x4x3 frame.
module tb_bnn_window_gen;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned C  = 3;
    localparam int unsigned DW = 9 * C;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    x;
        logic [1:0]    y;
        logic          last;
        int            cyc;
    } win_t;

    logic clk = 1'b0;
    logic rstn;
    logic clear;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    win_t         win_q [$];
    int           acc_q [$];
    logic [C-1:0] pix_q [$];
    int           trig  [4] = '{10, 11, 14, 15};

    always #5 clk = ~clk;

    bnn_window_gen_if #(.IMG_W(W), .IMG_H(H), .C(C)) bus ();

    bnn_window_gen #(.IMG_W(W), .IMG_H(H), .C(C)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every consumed window with the cycle it was first visible in.
    always @(negedge clk) begin
        if (rstn && bus.win_valid && bus.win_ready) begin
            win_t w;
            w.data = bus.win_data;
            w.x    = bus.win_x;
            w.y    = bus.win_y;
            w.last = bus.win_last;
            w.cyc  = cyc;
            win_q.push_back(w);
        end
    end

    // Reference window: pixel i of a frame is i mod 8, or a constant mask when use_mask is set.
    function automatic logic [DW-1:0] exp_win(input int x, input int y, input bit use_mask,
                                              input logic [C-1:0] m);
        logic [DW-1:0] res;
        logic [C-1:0]  p;
        res = '0;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 3; s++) begin
                p = use_mask ? m : C'(((y + r) * int'(W) + x + s) % 8);
                for (int ch = 0; ch < int'(C); ch++) res[ch*9 + 3*r + s] = p[ch];
            end
        return res;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_frame(input int n);
        for (int i = 0; i < n; i++) pix_q.push_back(C'(i % 8));
    endtask

    // Offer queued pixels; called and returns one time unit after a rising edge.
    task automatic drive(input bit rnd);
        int guard = 0;
        while (pix_q.size() > 0) begin
            bus.in_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.in_data  = pix_q[0];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready && !clear) begin
                acc_q.push_back(cyc + 1);
                void'(pix_q.pop_front());
            end
            @(posedge clk);
            #1;
            guard++;
            if (guard > 400) begin
                checks++;
                failures++;
                $display("FAIL drive_timeout got=%0d pixels left exp=0", pix_q.size());
                pix_q.delete();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.win_ready = 1'b1;
        tick(3);
        checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", bus.win_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.win_data !== '0) begin failures++; $display("FAIL reset_win_data got=%h exp=0", bus.win_data); end
        checks++; if ({bus.win_x, bus.win_y, bus.win_last} !== 5'b0) begin failures++; $display("FAIL reset_coord got=%b exp=00000", {bus.win_x, bus.win_y, bus.win_last}); end
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic test_basic;
        win_q.delete(); acc_q.delete();
        load_frame(16);
        drive(1'b0);
        tick(3);
        checks++; if (win_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", win_q.size()); end
        if (win_q.size() > 0) begin
            checks++; if (win_q[0].data !== 27'hE24892) begin failures++; $display("FAIL basic_first_const got=%h exp=e24892", win_q[0].data); end
        end
        for (int j = 0; j < win_q.size() && j < 4; j++) begin
            checks++; if (win_q[j].data !== exp_win(j % 2, j / 2, 1'b0, '0)) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", j, win_q[j].data, exp_win(j % 2, j / 2, 1'b0, '0)); end
            checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(j % 2), 2'(j / 2), (j == 3)}) begin failures++; $display("FAIL basic_xyl[%0d] got=%b exp=%b", j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(j % 2), 2'(j / 2), (j == 3)}); end
            checks++; if (win_q[j].cyc != acc_q[trig[j]]) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", j, win_q[j].cyc, acc_q[trig[j]]); end
        end
    endtask

    task automatic test_backpressure;
        win_q.delete(); acc_q.delete();
        load_frame(16);
        fork
            drive(1'b0);
            begin
                int g = 0;
                while (!bus.win_valid && g < 200) begin
                    @(posedge clk); #1; g++;
                end
                checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL bp_first_window got=%b exp=1", bus.win_valid); end
                bus.win_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
                    checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", bus.win_valid); end
                    checks++; if (bus.win_data !== exp_win(0, 0, 1'b0, '0)) begin failures++; $display("FAIL bp_hold_data got=%h exp=%h", bus.win_data, exp_win(0, 0, 1'b0, '0)); end
                    checks++; if ({bus.win_x, bus.win_y, bus.win_last} !== 5'b0) begin failures++; $display("FAIL bp_hold_xyl got=%b exp=00000", {bus.win_x, bus.win_y, bus.win_last}); end
                    @(posedge clk); #1;
                end
                bus.win_ready = 1'b1;
            end
        join
        tick(3);
        checks++; if (win_q.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", win_q.size()); end
        for (int j = 0; j < win_q.size() && j < 4; j++) begin
            checks++; if (win_q[j].data !== exp_win(j % 2, j / 2, 1'b0, '0)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", j, win_q[j].data, exp_win(j % 2, j / 2, 1'b0, '0)); end
            checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(j % 2), 2'(j / 2), (j == 3)}) begin failures++; $display("FAIL bp_xyl[%0d] got=%b exp=%b", j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(j % 2), 2'(j / 2), (j == 3)}); end
        end
    endtask

    task automatic test_back_to_back;
        int jj;
        int f;
        win_q.delete(); acc_q.delete();
        load_frame(32);
        drive(1'b0);
        tick(3);
        checks++; if (win_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", win_q.size()); end
        for (int j = 0; j < win_q.size() && j < 8; j++) begin
            jj = j % 4;
            f  = j / 4;
            checks++; if (win_q[j].data !== exp_win(jj % 2, jj / 2, 1'b0, '0)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", j, win_q[j].data, exp_win(jj % 2, jj / 2, 1'b0, '0)); end
            checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(jj % 2), 2'(jj / 2), (jj == 3)}) begin failures++; $display("FAIL b2b_xyl[%0d] got=%b exp=%b", j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(jj % 2), 2'(jj / 2), (jj == 3)}); end
            checks++; if (win_q[j].cyc != acc_q[f*16 + trig[jj]]) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", j, win_q[j].cyc, acc_q[f*16 + trig[jj]]); end
        end
    endtask

    task automatic test_reset_mid;
        bus.win_ready = 1'b0;
        load_frame(11);
        drive(1'b0);
        checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", bus.win_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", bus.win_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.win_data, bus.win_x, bus.win_y, bus.win_last} !== '0) begin failures++; $display("FAIL rst_async_out got=%h exp=0", {bus.win_data, bus.win_x, bus.win_y, bus.win_last}); end
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.win_ready = 1'b1;
        win_q.delete(); acc_q.delete();
        load_frame(16);
        drive(1'b0);
        tick(3);
        checks++; if (win_q.size() != 4) begin failures++; $display("FAIL rst_count got=%0d exp=4", win_q.size()); end
        for (int j = 0; j < win_q.size() && j < 4; j++) begin
            checks++; if (win_q[j].data !== exp_win(j % 2, j / 2, 1'b0, '0)) begin failures++; $display("FAIL rst_data[%0d] got=%h exp=%h", j, win_q[j].data, exp_win(j % 2, j / 2, 1'b0, '0)); end
            checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(j % 2), 2'(j / 2), (j == 3)}) begin failures++; $display("FAIL rst_xyl[%0d] got=%b exp=%b", j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(j % 2), 2'(j / 2), (j == 3)}); end
            checks++; if (win_q[j].cyc != acc_q[trig[j]]) begin failures++; $display("FAIL rst_latency[%0d] got=%0d exp=%0d", j, win_q[j].cyc, acc_q[trig[j]]); end
        end
    endtask

    task automatic test_clear;
        bus.win_ready = 1'b0;
        load_frame(11);
        drive(1'b0);
        checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL clr_pre_valid got=%b exp=1", bus.win_valid); end
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 3'b111;
        tick(1);
        checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", bus.win_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b exp=1", bus.in_ready); end
        tick(1);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.win_ready = 1'b1;
        win_q.delete(); acc_q.delete();
        load_frame(16);
        drive(1'b0);
        tick(3);
        checks++; if (win_q.size() != 4) begin failures++; $display("FAIL clr_count got=%0d exp=4", win_q.size()); end
        for (int j = 0; j < win_q.size() && j < 4; j++) begin
            checks++; if (win_q[j].data !== exp_win(j % 2, j / 2, 1'b0, '0)) begin failures++; $display("FAIL clr_data[%0d] got=%h exp=%h", j, win_q[j].data, exp_win(j % 2, j / 2, 1'b0, '0)); end
            checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(j % 2), 2'(j / 2), (j == 3)}) begin failures++; $display("FAIL clr_xyl[%0d] got=%b exp=%b", j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(j % 2), 2'(j / 2), (j == 3)}); end
        end
    endtask

    task automatic test_random_valid;
        logic [DW-1:0] e;
        logic [C-1:0]  m;
        for (int ch = 1; ch < int'(C); ch++) begin
            m = '0;
            m[ch] = 1'b1;
            e = '0;
            e[9*ch +: 9] = 9'h1FF;
            win_q.delete(); acc_q.delete();
            for (int i = 0; i < 16; i++) pix_q.push_back(m);
            drive(1'b1);
            tick(3);
            checks++; if (win_q.size() != 4) begin failures++; $display("FAIL rnd_count[ch%0d] got=%0d exp=4", ch, win_q.size()); end
            for (int j = 0; j < win_q.size() && j < 4; j++) begin
                checks++; if (win_q[j].data !== e) begin failures++; $display("FAIL rnd_data[ch%0d][%0d] got=%h exp=%h", ch, j, win_q[j].data, e); end
                checks++; if ({win_q[j].x, win_q[j].y, win_q[j].last} !== {2'(j % 2), 2'(j / 2), (j == 3)}) begin failures++; $display("FAIL rnd_xyl[ch%0d][%0d] got=%b exp=%b", ch, j, {win_q[j].x, win_q[j].y, win_q[j].last}, {2'(j % 2), 2'(j / 2), (j == 3)}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        test_random_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
